wb_burst_reader: RTL and testbench

- Wishbone master that fetches a block of consecutive 32-bit words from a Wishbone slave (e.g. a block-RAM controller) and presents them on a valid/ready stream.
- Uses incrementing-burst read cycles (CTI/BTE registered feedback), so a burst-capable slave returns one word per clock.
- Buffers returned words in an internal FIFO so that downstream back-pressure becomes Wishbone master wait states.
- Sits between a control/DMA sequencer and the memory bus.

---
 rtl/wb_burst_reader_if.sv | 38 +++
 rtl/wb_burst_reader.sv | 188 ++++++++++++++++++
 tb/tb_wb_burst_reader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_reader_if.sv
// ----------------------------------------------------------------------------
// wb_burst_reader_if
//   Wishbone B4 bus bundle with registered-feedback burst tags (CTI/BTE).
//
//   Signals:
//     cyc, stb, we   cycle, strobe, write enable      (master -> slave)
//     adr[31:0]      byte address                     (master -> slave)
//     sel[3:0]       byte lane select                 (master -> slave)
//     cti[2:0]       cycle type identifier            (master -> slave)
//     bte[1:0]       burst type extension             (master -> slave)
//     dat_ms[31:0]   write data                       (master -> slave)
//     dat_sm[31:0]   read data                        (slave -> master)
//     ack, err, rty  cycle termination                (slave -> master)
// ----------------------------------------------------------------------------
interface wb_burst_reader_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, sel, cti, bte, dat_ms,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wb_burst_reader.sv
// ----------------------------------------------------------------------------
// wb_burst_reader
//   Wishbone master that reads a block of consecutive 32-bit words using
//   incrementing-burst cycles and streams them out through a small FIFO.
//   When the FIFO fills, stb is withheld, so downstream back-pressure turns
//   into master wait states on the bus.
//
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     start                one-cycle request, accepted only when idle
//     base_adr[31:0]       byte start address (bits [1:0] ignored)
//     len[LEN_W-1:0]       number of words to read (0 = empty transfer)
//     busy                 transfer in progress, through the done cycle
//     done                 one-cycle end-of-transfer pulse
//     error                qualified by done: transfer ended by err/rty
//     wb_m                 Wishbone master port
//     rd_data[31:0]        FIFO head word
//     rd_valid             FIFO not empty
//     rd_ready             consumer accepts rd_data
// ----------------------------------------------------------------------------
module wb_burst_reader #(
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          base_adr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    wb_burst_reader_if.master    wb_m,
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t           state;
    logic             cyc_q;
    logic [31:0]      adr_q;
    logic [LEN_W-1:0] remaining;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_full;
    logic stb;
    logic last_beat;
    logic beat_term;
    logic beat_ack;
    logic push;
    logic pop;

    // The two low address bits are dropped on purpose: transfers are word aligned.
    logic unused_adr_bits;
    assign unused_adr_bits = ^base_adr[1:0];

    // stb looks only at the registered count, so a pop in this cycle cannot
    // open room for a beat in the same cycle; this keeps the bus path short.
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign stb       = cyc_q & ~fifo_full;
    assign last_beat = (remaining == LEN_W'(1));

    // err/rty win over ack when a slave drives several terminations at once.
    assign beat_term = stb & (wb_m.err | wb_m.rty);
    assign beat_ack  = stb & wb_m.ack & ~(wb_m.err | wb_m.rty);
    assign push      = beat_ack;
    assign pop       = rd_valid & rd_ready;

    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = stb;
    assign wb_m.we     = 1'b0;
    assign wb_m.adr    = adr_q;
    assign wb_m.sel    = 4'hF;
    assign wb_m.cti    = cyc_q ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wb_m.bte    = 2'b00;
    assign wb_m.dat_ms = 32'h0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc_q     <= 1'b0;
            adr_q     <= 32'h0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // done/error are single-cycle pulses unless set below.
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            adr_q     <= {base_adr[31:2], 2'b00};
                            remaining <= len;
                            cyc_q     <= 1'b1;
                            state     <= BURST;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                BURST: begin
                    if (beat_term) begin
                        cyc_q <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= DONE;
                    end else if (beat_ack) begin
                        adr_q     <= adr_q + 32'd4;
                        remaining <= remaining - LEN_W'(1);
                        if (last_beat) begin
                            cyc_q <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cyc_q <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-data FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are live, so flushing them is enough and the array can
    // map onto plain RAM or LUT storage.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wb_m.dat_sm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_wb_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_wb_burst_reader
//   Directed bench for wb_burst_reader. A behavioural burst slave answers
//   strobes and checks each beat's address/CTI against an expected-beat queue;
//   a separate stream monitor pops expected words whenever a word is handed
//   over on rd_valid/rd_ready.
// ----------------------------------------------------------------------------
module tb_wb_burst_reader;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_adr = 32'h0;
    logic [11:0] len = 12'd0;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;

    wb_burst_reader_if wb ();

    wb_burst_reader #(
        .LEN_W      (12),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_adr (base_adr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .wb_m     (wb),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready)
    );

    always #5 clk = ~clk;

    int          cycle_no = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;

    logic [31:0] exp_q[$];
    beat_t       beat_q[$];

    // Slave configuration (written by the stimulus process only).
    int          wait_first = 0;
    int          err_beat   = 0;
    logic [31:0] seed       = 32'h0;
    logic [31:0] txn_base   = 32'h0;

    // Slave observations (written by the slave process only).
    int          beat_total      = 0;
    int          first_stb_cycle = 0;
    int          last_resp_cycle = 0;
    logic [31:0] max_adr         = 32'h0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [2:0] c);
        beat_t b;
        b.adr = a;
        b.cti = c;
        beat_q.push_back(b);
    endtask

    // ------------------------------------------------------------------
    // Behavioural burst slave: answers in the cycle stb is seen, with an
    // optional wait on the first beat and an optional err on one beat.
    // ------------------------------------------------------------------
    initial begin
        int    s_idx;
        int    s_waited;
        bit    s_started;
        beat_t b;
        s_idx     = 0;
        s_waited  = 0;
        s_started = 0;
        wb.ack    = 1'b0;
        wb.err    = 1'b0;
        wb.rty    = 1'b0;
        wb.dat_sm = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            wb.ack    = 1'b0;
            wb.err    = 1'b0;
            wb.dat_sm = 32'h0;
            if (!wb.cyc) begin
                s_idx     = 0;
                s_waited  = 0;
                s_started = 0;
            end else if (wb.stb) begin
                if (!s_started) begin
                    s_started       = 1;
                    first_stb_cycle = cycle_no;
                    max_adr         = wb.adr;
                end
                if (wb.adr > max_adr) max_adr = wb.adr;
                if (s_idx == 0 && s_waited < wait_first) begin
                    s_waited++;
                end else begin
                    if (beat_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("FAIL beat_extra: got adr 0x%08h, expected no beat", wb.adr);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_adr", wb.adr, b.adr);
                        check("beat_cti", {29'b0, wb.cti}, {29'b0, b.cti});
                    end
                    if (s_idx + 1 == err_beat) begin
                        wb.err = 1'b1;
                    end else begin
                        wb.ack    = 1'b1;
                        wb.dat_sm = seed + ((wb.adr - txn_base) >> 2);
                    end
                    s_idx++;
                    beat_total++;
                    last_resp_cycle = cycle_no;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stream monitor: compares every accepted word with the scoreboard.
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL rd_extra: got 0x%08h, expected no word", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int start_cycle = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] b, input logic [11:0] l);
        start       = 1'b1;
        base_adr    = b;
        len         = l;
        start_cycle = cycle_no;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dc);
        bit ok;
        ok = 0;
        dc = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                ok = 1;
                dc = cycle_no;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", limit);
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && !rd_valid) break;
            tick();
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", {31'b0, rd_valid}, 0);
    endtask

    initial begin
        int dc;
        int bt0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_cyc",   {31'b0, wb.cyc},   0);
        check("rst_stb",   {31'b0, wb.stb},   0);
        check("rst_busy",  {31'b0, busy},     0);
        check("rst_done",  {31'b0, done},     0);
        check("rst_error", {31'b0, error},    0);
        check("rst_valid", {31'b0, rd_valid}, 0);
        check("rst_adr",   wb.adr,            32'h0);
        check("rst_cti",   {29'b0, wb.cti},   0);
        rst = 1'b0;
        tick();

        // T1: single word, immediate ack
        rd_ready   = 1'b1;
        seed       = 32'hCAFE0001;
        txn_base   = 32'h100;
        wait_first = 0;
        err_beat   = 0;
        push_beat(32'h100, 3'b111);
        exp_q.push_back(32'hCAFE0001);
        bt0 = beat_total;
        issue(32'h100, 12'd1);
        check("t1_busy", {31'b0, busy}, 1);
        wait_done(10, dc);
        check("t1_stb_lat",  first_stb_cycle, start_cycle + 1);
        check("t1_done_lat", dc, last_resp_cycle + 1);
        check("t1_error",    {31'b0, error}, 0);
        check("t1_beats",    beat_total - bt0, 1);
        drain(20);

        // T2: misaligned base, one wait state on the first beat
        seed       = 32'h11110000;
        txn_base   = 32'h200;
        wait_first = 1;
        push_beat(32'h200, 3'b010);
        push_beat(32'h204, 3'b010);
        push_beat(32'h208, 3'b010);
        push_beat(32'h20C, 3'b111);
        exp_q.push_back(32'h11110000);
        exp_q.push_back(32'h11110001);
        exp_q.push_back(32'h11110002);
        exp_q.push_back(32'h11110003);
        bt0 = beat_total;
        issue(32'h203, 12'd4);
        wait_done(20, dc);
        check("t2_stb_lat",  first_stb_cycle, start_cycle + 1);
        check("t2_done_lat", dc, last_resp_cycle + 1);
        check("t2_error",    {31'b0, error}, 0);
        check("t2_beats",    beat_total - bt0, 4);
        wait_first = 0;
        drain(20);

        // T3: consumer stalled, FIFO fills and stb is withheld
        rd_ready = 1'b0;
        seed     = 32'h22220000;
        txn_base = 32'h1000;
        for (int i = 0; i < 12; i++) begin
            push_beat(32'h1000 + 32'(4 * i), (i == 11) ? 3'b111 : 3'b010);
            exp_q.push_back(32'h22220000 + 32'(i));
        end
        bt0 = beat_total;
        issue(32'h1000, 12'd12);
        repeat (14) tick();
        check("t3_stall_beats", beat_total - bt0, 8);
        check("t3_stall_stb",   {31'b0, wb.stb},   0);
        check("t3_stall_cyc",   {31'b0, wb.cyc},   1);
        check("t3_stall_valid", {31'b0, rd_valid}, 1);
        rd_ready = 1'b1;
        wait_done(40, dc);
        check("t3_error", {31'b0, error}, 0);
        check("t3_beats", beat_total - bt0, 12);
        drain(30);

        // T4: err on the third beat
        rd_ready = 1'b0;
        seed     = 32'h33330000;
        txn_base = 32'h300;
        err_beat = 3;
        push_beat(32'h300, 3'b010);
        push_beat(32'h304, 3'b010);
        push_beat(32'h308, 3'b010);
        exp_q.push_back(32'h33330000);
        exp_q.push_back(32'h33330001);
        bt0 = beat_total;
        issue(32'h300, 12'd6);
        wait_done(20, dc);
        check("t4_error",    {31'b0, error}, 1);
        check("t4_done_lat", dc, last_resp_cycle + 1);
        tick();
        check("t4_cyc_after", {31'b0, wb.cyc}, 0);
        check("t4_max_adr",   max_adr, 32'h308);
        check("t4_beats",     beat_total - bt0, 3);
        check("t4_valid",     {31'b0, rd_valid}, 1);
        err_beat = 0;
        rd_ready = 1'b1;
        drain(20);

        // T5a: zero-length transfer
        bt0 = beat_total;
        issue(32'h700, 12'd0);
        wait_done(5, dc);
        check("t5_zero_lat",   dc, start_cycle + 1);
        check("t5_zero_error", {31'b0, error}, 0);
        check("t5_zero_cyc",   {31'b0, wb.cyc}, 0);
        tick();
        check("t5_zero_beats", beat_total - bt0, 0);

        // T5b: starts while busy and in the done cycle are ignored
        seed     = 32'h44440000;
        txn_base = 32'h400;
        for (int i = 0; i < 5; i++) begin
            push_beat(32'h400 + 32'(4 * i), (i == 4) ? 3'b111 : 3'b010);
            exp_q.push_back(32'h44440000 + 32'(i));
        end
        bt0 = beat_total;
        issue(32'h400, 12'd5);
        start    = 1'b1;
        base_adr = 32'h800;
        len      = 12'd3;
        tick();
        start = 1'b0;
        wait_done(20, dc);
        check("t5_error", {31'b0, error}, 0);
        start    = 1'b1;
        base_adr = 32'h900;
        len      = 12'd2;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t5_busy_after", {31'b0, busy},   0);
        check("t5_cyc_after",  {31'b0, wb.cyc}, 0);
        check("t5_beats",      beat_total - bt0, 5);
        drain(20);

        // T6: reset during the third beat, then a clean transfer
        rd_ready = 1'b0;
        seed     = 32'h55550000;
        txn_base = 32'h500;
        for (int i = 0; i < 8; i++) begin
            push_beat(32'h500 + 32'(4 * i), (i == 7) ? 3'b111 : 3'b010);
        end
        issue(32'h500, 12'd8);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_cyc",   {31'b0, wb.cyc},   0);
        check("t6_rst_stb",   {31'b0, wb.stb},   0);
        check("t6_rst_busy",  {31'b0, busy},     0);
        check("t6_rst_valid", {31'b0, rd_valid}, 0);
        check("t6_rst_adr",   wb.adr,            32'h0);
        beat_q.delete();
        tick();

        rd_ready = 1'b1;
        seed     = 32'h66660000;
        txn_base = 32'h600;
        push_beat(32'h600, 3'b010);
        push_beat(32'h604, 3'b111);
        exp_q.push_back(32'h66660000);
        exp_q.push_back(32'h66660001);
        bt0 = beat_total;
        issue(32'h600, 12'd2);
        wait_done(20, dc);
        check("t6_error",    {31'b0, error}, 0);
        check("t6_done_lat", dc, last_resp_cycle + 1);
        check("t6_beats",    beat_total - bt0, 2);
        drain(20);
        check("beats_left", beat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
